// File: rtl/act_mon_pkg.sv
// Shared types and helpers for the toggle activity monitor.
package act_mon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        COUNT,
        DRAIN,
        TOTAL
    } state_t;

    localparam int CNT_W_DEF = 16;
    localparam int OUT_W     = CNT_W_DEF + 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Callers zero-extend their vector into the 64-bit argument.
    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + {6'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/popcount_sat.sv
// Bank of per-bit saturating toggle counters with a sticky saturation flag.
module popcount_sat
    import act_mon_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         en,
    input  logic [WIDTH-1:0]             tog,
    output logic [WIDTH-1:0][CNT_W-1:0]  cnt,
    output logic                         sat
);

    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    // sat is raised on the increment that lands a counter on its ceiling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (tog[i] && (cnt[i] != MAX_CNT)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                    if (cnt[i] == MAX_CNT - CNT_W'(1)) sat <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/toggle_activity_monitor.sv
// Measures per-bit and total switching activity of a vector over a window of
// transitions, then streams the counts out over a valid/ready port.
module toggle_activity_monitor
    import act_mon_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIN_W-1:0]   win_len,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_vec,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W+3:0]   out_data,
    output logic               out_last,
    output logic               sat,
    output logic               done
);

    localparam int OW = CNT_W + 4;
    localparam int IW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t                      state;
    state_t                      state_next;
    logic                        done_next;
    logic [WIN_W-1:0]            win_q;
    logic [WIN_W-1:0]            sample_cnt;
    logic [WIDTH-1:0]            prev_vec;
    logic [WIDTH-1:0]            tog;
    logic [IW-1:0]               idx;
    logic [OW-1:0]               total;
    logic [WIDTH-1:0][CNT_W-1:0] cnt;
    logic                        clear_run;
    logic                        count_en;
    logic                        handshake;
    logic                        window_end;

    assign clear_run  = (state == IDLE) && start && (win_len != '0);
    assign count_en   = (state == COUNT) && in_valid && !abort;
    assign handshake  = out_valid && out_ready;
    assign tog        = in_vec ^ prev_vec;
    assign window_end = (sample_cnt + WIN_W'(1)) == win_q;
    assign busy       = (state != IDLE);

    popcount_sat #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_run),
        .en    (count_en),
        .tog   (tog),
        .cnt   (cnt),
        .sat   (sat)
    );

    // abort wins over window completion and over any handshake.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE:  if (clear_run) state_next = ARM;
            ARM: begin
                if (abort)         state_next = IDLE;
                else if (in_valid) state_next = COUNT;
            end
            COUNT: begin
                if (abort)                       state_next = IDLE;
                else if (in_valid && window_end) state_next = DRAIN;
            end
            DRAIN: begin
                if (abort)                                state_next = IDLE;
                else if (handshake && (idx == LAST_IDX))  state_next = TOTAL;
            end
            TOTAL: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (handshake) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    // idx is cleared on start and only moves in DRAIN, so DRAIN always begins at beat 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q      <= '0;
            sample_cnt <= '0;
            prev_vec   <= '0;
            idx        <= '0;
            total      <= '0;
        end else begin
            if (clear_run) begin
                win_q      <= win_len;
                sample_cnt <= '0;
                total      <= '0;
                idx        <= '0;
            end
            if ((state == ARM) && in_valid && !abort) begin
                prev_vec <= in_vec;
            end
            if (count_en) begin
                prev_vec   <= in_vec;
                total      <= total + OW'(popcount(64'(tog)));
                sample_cnt <= sample_cnt + WIN_W'(1);
            end
            if ((state == DRAIN) && handshake && !abort && (idx != LAST_IDX)) begin
                idx <= idx + IW'(1);
            end
        end
    end

    // Output words are decoded from registered state only, so out_ready never reaches them.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state)
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = OW'(cnt[idx]);
            end
            TOTAL: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = total;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Drives a 16-bit and a 4-bit counter instance in lockstep and checks both
// against a reference built from the recorded sample sequence.
module tb_toggle_activity_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] win_len;
    logic        in_valid;
    logic [10:0] in_vec;
    logic        out_ready;

    logic        b16, v16, l16, s16, d16;
    logic [19:0] o16;
    logic        b4, v4, l4, s4, d4;
    logic [7:0]  o4;

    int vectors     = 0;
    int miscompares = 0;

    logic [10:0] samples[$];
    int exp16[11];
    int exp4[11];
    int etot16, etot4;
    bit esat16, esat4;

    always #5 clk = ~clk;

    toggle_activity_monitor #(.WIDTH(11), .CNT_W(16), .WIN_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len),
        .in_valid(in_valid), .in_vec(in_vec), .busy(b16), .out_valid(v16),
        .out_ready(out_ready), .out_data(o16), .out_last(l16), .sat(s16), .done(d16)
    );

    toggle_activity_monitor #(.WIDTH(11), .CNT_W(4), .WIN_W(16)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len),
        .in_valid(in_valid), .in_vec(in_vec), .busy(b4), .out_valid(v4),
        .out_ready(out_ready), .out_data(o4), .out_last(l4), .sat(s4), .done(d4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [10:0] v, input bit valid);
        in_vec   = v;
        in_valid = valid;
        @(negedge clk);
        in_valid = 1'b0;
        if (valid) samples.push_back(v);
    endtask

    task automatic startRun(input logic [15:0] len);
        start   = 1'b1;
        win_len = len;
        @(negedge clk);
        start = 1'b0;
        samples.delete();
    endtask

    task automatic feedRandom(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) applyStimulus(11'($urandom), 1'b0);
            end
            applyStimulus(11'($urandom), 1'b1);
        end
    endtask

    // Count bit changes between consecutive recorded samples, then apply each ceiling.
    task automatic computeModel();
        int tg[11];
        int tot;
        logic [10:0] diff;
        tot = 0;
        for (int b = 0; b < 11; b++) tg[b] = 0;
        for (int k = 1; k < samples.size(); k++) begin
            diff = samples[k] ^ samples[k-1];
            for (int b = 0; b < 11; b++) if (diff[b]) tg[b]++;
        end
        esat16 = 1'b0;
        esat4  = 1'b0;
        for (int b = 0; b < 11; b++) begin
            exp16[b] = (tg[b] > 65535) ? 65535 : tg[b];
            exp4[b]  = (tg[b] > 15) ? 15 : tg[b];
            if (tg[b] >= 65535) esat16 = 1'b1;
            if (tg[b] >= 15)    esat4  = 1'b1;
            tot += tg[b];
        end
        etot16 = tot % (1 << 20);
        etot4  = tot % 256;
    endtask

    task automatic drainAndCheck(input string tag, input int bp_beat, input int bp_len,
                                 input bit rnd);
        int beat;
        int held;
        int cyc;
        bit rdy;
        beat = 0;
        held = 0;
        cyc  = 0;
        computeModel();
        checkOutput({tag, "/sat16"}, 32'(s16), 32'(esat16));
        checkOutput({tag, "/sat4"},  32'(s4),  32'(esat4));
        while (beat < 12 && cyc < 300) begin
            checkOutput({tag, "/valid16"}, 32'(v16), 32'(1));
            checkOutput({tag, "/valid4"},  32'(v4),  32'(1));
            checkOutput({tag, "/data16"}, 32'(o16), 32'((beat < 11) ? exp16[beat] : etot16));
            checkOutput({tag, "/data4"},  32'(o4),  32'((beat < 11) ? exp4[beat]  : etot4));
            checkOutput({tag, "/last16"}, 32'(l16), 32'(beat == 11));
            checkOutput({tag, "/last4"},  32'(l4),  32'(beat == 11));
            if (beat == bp_beat && held < bp_len) begin
                rdy = 1'b0;
                held++;
            end else if (rnd) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            out_ready = rdy;
            @(negedge clk);
            if (rdy) beat++;
            cyc++;
        end
        out_ready = 1'b0;
        checkOutput({tag, "/beats"}, 32'(beat), 32'(12));
        checkOutput({tag, "/done16"}, 32'(d16), 32'(1));
        checkOutput({tag, "/done4"},  32'(d4),  32'(1));
        checkOutput({tag, "/busy_end"}, 32'({b16, b4}), 32'(0));
        checkOutput({tag, "/valid_end"}, 32'({v16, v4}), 32'(0));
        @(negedge clk);
        checkOutput({tag, "/done_pulse"}, 32'({d16, d4}), 32'(0));
    endtask

    initial begin
        logic [10:0] gvec[7];

        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b0;
        win_len   = '0;

        #1;
        checkOutput("reset/ctl16", 32'({b16, v16, l16, s16, d16}), 32'(0));
        checkOutput("reset/ctl4",  32'({b4, v4, l4, s4, d4}), 32'(0));
        checkOutput("reset/data16", 32'(o16), 32'(0));
        checkOutput("reset/data4",  32'(o4),  32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Directed basic window
        startRun(16'd3);
        checkOutput("basic/busy", 32'({b16, b4}), 32'(3));
        applyStimulus(11'h000, 1'b1);
        applyStimulus(11'h7FF, 1'b1);
        applyStimulus(11'h7FF, 1'b1);
        applyStimulus(11'h001, 1'b1);
        drainAndCheck("basic", -1, 0, 1'b0);

        // Same window with a stalled beat
        startRun(16'd3);
        applyStimulus(11'h000, 1'b1);
        applyStimulus(11'h7FF, 1'b1);
        applyStimulus(11'h7FF, 1'b1);
        applyStimulus(11'h001, 1'b1);
        drainAndCheck("backpressure", 4, 5, 1'b0);

        // Bit 0 toggles 20 times: saturates the 4-bit bank only
        startRun(16'd20);
        for (int k = 0; k <= 20; k++) applyStimulus(11'(k % 2), 1'b1);
        drainAndCheck("saturation", -1, 0, 1'b0);

        // Zero-length start is ignored and leaves sat alone
        startRun(16'd0);
        checkOutput("guard/zero_busy", 32'({b16, b4}), 32'(0));
        checkOutput("guard/zero_sat4", 32'(s4), 32'(1));
        startRun(16'd5);
        checkOutput("guard/sat_cleared", 32'(s4), 32'(0));
        feedRandom(3, 1'b0);
        start   = 1'b1;
        win_len = 16'd2;
        applyStimulus(11'($urandom), 1'b1);
        start = 1'b0;
        feedRandom(2, 1'b0);
        drainAndCheck("guard", -1, 0, 1'b0);

        // Abort mid-count after saturating the 4-bit bank
        startRun(16'd30);
        for (int k = 0; k <= 16; k++) applyStimulus(11'(k % 2), 1'b1);
        checkOutput("abort/sat4_pre", 32'(s4), 32'(1));
        checkOutput("abort/busy_pre", 32'({b16, b4}), 32'(3));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort/busy", 32'({b16, b4}), 32'(0));
        checkOutput("abort/sat4_kept", 32'(s4), 32'(1));
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_vec   = 11'($urandom);
            @(negedge clk);
            checkOutput("abort/idle_valid", 32'({v16, v4}), 32'(0));
            checkOutput("abort/idle_done",  32'({d16, d4}), 32'(0));
        end
        in_valid = 1'b0;
        startRun(16'd4);
        checkOutput("abort/restart_sat4", 32'(s4), 32'(0));
        feedRandom(5, 1'b0);
        drainAndCheck("abort_restart", -1, 0, 1'b0);

        // Gapless vs gapped delivery of the same samples
        for (int k = 0; k < 7; k++) gvec[k] = 11'($urandom);
        startRun(16'd6);
        for (int k = 0; k < 7; k++) applyStimulus(gvec[k], 1'b1);
        drainAndCheck("gapless", -1, 0, 1'b0);
        startRun(16'd6);
        for (int k = 0; k < 7; k++) begin
            repeat ($urandom_range(1, 3)) applyStimulus(11'($urandom), 1'b0);
            applyStimulus(gvec[k], 1'b1);
        end
        in_valid = 1'b1;
        in_vec   = 11'($urandom);
        drainAndCheck("gapped", -1, 0, 1'b0);
        in_valid = 1'b0;

        // Asynchronous reset in the middle of the drain
        startRun(16'd3);
        feedRandom(4, 1'b0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        checkOutput("rstdrain/valid_pre", 32'({v16, v4}), 32'(3));
        rst = 1'b1;
        #1;
        checkOutput("rstdrain/ctl16", 32'({b16, v16, l16, s16, d16}), 32'(0));
        checkOutput("rstdrain/ctl4",  32'({b4, v4, l4, s4, d4}), 32'(0));
        checkOutput("rstdrain/data",  32'({o16, o4}), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Random windows with random gaps and random backpressure
        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(1, 12);
            startRun(16'(len));
            feedRandom(len + 1, 1'b1);
            drainAndCheck($sformatf("random%0d", r), -1, 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/toggle_activity_monitor.md
Name: toggle_activity_monitor

Overview:
- Downstream stage of the dk17 combinational benchmark netlist.
- Consumes the 11-bit v10 output vector and measures switching activity over a programmable window of transitions.
- Keeps a per-bit toggle count and a total toggle count.
- After the window closes, streams the WIDTH per-bit counts and then the total over a valid/ready interface to the power-estimation collector.

Parameters:
- WIDTH, 11: width of the observed vector (dk17 v10.0..v10.10).
- CNT_W, 16: width of each per-bit toggle counter; counters saturate.
- WIN_W, 16: width of the window-length input.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  one-cycle request to begin a measurement run.
- abort  input  1  synchronous abort of the run in progress.
- win_len  input  WIN_W  number of transitions to count; sampled on accepted start.
- in_valid  input  1  in_vec is a valid sample this cycle.
- in_vec  input  WIDTH  observed vector (bit i = v10.i).
- busy  output  1  high in every state except IDLE.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  CNT_W+4  per-bit count (zero-extended) or total.
- out_last  output  1  high with the total word (final beat).
- sat  output  1  sticky: a per-bit counter saturated during this run.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (async, active-high): state=IDLE; all counters, prev and idx cleared; busy, out_valid, out_last, sat, done and out_data all 0.
- States: IDLE, ARM, COUNT, DRAIN, TOTAL.
- IDLE:
  - start with win_len!=0: latch win_len, clear counters, total, sample count and sat; go to ARM.
  - start with win_len==0 is ignored; stay in IDLE.
- ARM: the first in_valid sample loads prev; no toggles are counted for it; go to COUNT.
- COUNT, on each in_valid:
  - tog = in_vec ^ prev.
  - cnt[i] += tog[i], saturating at 2^CNT_W-1; reaching saturation sets sat.
  - total += popcount(tog); total has CNT_W+4 bits and is not saturated.
  - prev <= in_vec; sample count += 1.
  - When the sample count reaches the latched win_len, go to DRAIN with idx=0.
  - A run therefore consumes win_len+1 samples.
- Timing: counter updates are visible one cycle after the sample edge. in_valid is ignored in IDLE, DRAIN and TOTAL.
- DRAIN:
  - out_valid=1, out_data=cnt[idx], out_last=0.
  - On out_valid&out_ready: idx+1. On the transfer with idx=WIDTH-1, go to TOTAL.
- TOTAL:
  - out_valid=1, out_data=total, out_last=1.
  - On handshake: go to IDLE, pulse done for one cycle.
- Output stability: out_data and out_last are held stable while out_valid&!out_ready (registered outputs, no combinational path from out_ready to out_data).
- start while busy is ignored.
- abort in any non-IDLE state:
  - Next state IDLE; out_valid drops the next cycle; no done pulse.
  - Counters are kept until the next accepted start.
- abort takes priority over a simultaneous handshake or window completion.
- Reset mid-run (including during DRAIN) returns to the reset values immediately.
- sat stays set until the next accepted start or reset.

Decomposition:
- Package act_mon_pkg holds:
  - state enum (IDLE, ARM, COUNT, DRAIN, TOTAL);
  - localparam OUT_W = CNT_W+4;
  - function clog2;
  - function popcount over WIDTH bits.
- Sub-module popcount_sat: the per-bit saturating increment bank (WIDTH counters and the sat flag). The FSM and drain mux stay in the top module.

Test Plan:
- Basic count: win_len=3; samples 0x000, 0x7FF, 0x7FF, 0x001 -> beats: cnt[0]=1, cnt[1..10]=2, then total=21 with out_last=1; done pulses once; busy falls with done.
- Backpressure: same run with out_ready low for 5 cycles at idx=4 -> out_data holds 2, out_valid stays high, idx does not advance; 12 beats total.
- Saturation: CNT_W=4; win_len=20; alternate 0x000/0x001 -> cnt[0]=15, sat=1, total=20, other counts 0.
- Guard: start with win_len=0 -> busy stays 0; start pulsed during COUNT -> ignored, run completes normally.
- Abort: abort during COUNT after 2 transitions -> IDLE next cycle, out_valid never rises, no done; a new start clears counters and sat.
- Gapped input and reset: in_valid gaps during COUNT -> result identical to the gapless run. Async rst asserted mid-DRAIN -> out_valid=0 immediately, state IDLE, all outputs 0.
